// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-subset control unit with retired counter and sticky illegal flag
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11
  } state_t;
  state_t st, nxt;
  logic pw, pwc, mw, irw, rw, bad, done;
  assign state = st;
  assign pc_write = pw & ~reset;
  assign pc_write_cond = pwc & ~reset;
  assign mem_write = mw & ~reset;
  assign ir_write = irw & ~reset;
  assign reg_write = rw & ~reset;
  assign done = st inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB};
  // state register, retired counter and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      st <= nxt;
      retired <= done ? retired + 1'b1 : retired;
      illegal <= illegal | bad;
    end
  end
  // Moore output decode from state; opcode only steers the next state
  always_comb begin
    nxt = FETCH;
    bad = 1'b0;
    pw = 1'b0;
    pwc = 1'b0;
    mw = 1'b0;
    irw = 1'b0;
    rw = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_source = 2'b00;
    case (st)
      FETCH: begin
        mem_read = 1'b1;
        irw = 1'b1;
        alu_src_b = 2'b01;
        pw = 1'b1;
        nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000: nxt = EXEC;
          6'b000100: nxt = BRANCH;
          6'b000010: nxt = JUMP;
          6'b001000: nxt = ADDIEX;
          default: bad = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        rw = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mw = 1'b1;
        i_or_d = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op = 2'b10;
        nxt = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        reg_dst = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 2'b01;
        pwc = 1'b1;
        pc_source = 2'b01;
      end
      JUMP: begin
        pw = 1'b1;
        pc_source = 2'b10;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: rw = 1'b1;
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: randomized instruction stream checked against a per-instruction reference model
module tb_mc_control_fsm;
  localparam int CNT_W = 4;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  typedef int q_t[$];
  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic [CNT_W-1:0] retired;
  logic illegal;
  int checks = 0, failures = 0;
  int retired_m = 0;
  logic illegal_m = 1'b0;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  function automatic q_t seq_of(input logic [5:0] op);
    case (op)
      LW: return '{0, 1, 2, 3, 4};
      SW: return '{0, 1, 2, 5};
      RT: return '{0, 1, 6, 7};
      ADDI: return '{0, 1, 10, 11};
      BEQ: return '{0, 1, 8};
      JMP: return '{0, 1, 9};
      default: return '{0, 1};
    endcase
  endfunction

  function automatic logic [15:0] exp_ctrl(input int s);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps} = '0;
    case (s)
      0: begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
      1: asb = 2'b11;
      2: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin asa = 1; aop = 2'b10; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9: begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle(input int s, input bit in_reset);
    logic [15:0] c;
    #1;
    c = exp_ctrl(s) & (in_reset ? 16'h337F : 16'hFFFF);
    check("state", {28'b0, state}, s);
    check("ctrl", {16'b0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}, {16'b0, c});
    check("retired", {28'b0, retired}, retired_m);
    check("illegal", {31'b0, illegal}, {31'b0, illegal_m});
  endtask

  task automatic do_reset(input int s);
    reset = 1'b1;
    check_cycle(s, 1'b1);
    @(posedge clk);
    #1;
    retired_m = 0;
    illegal_m = 1'b0;
    check_cycle(0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op, input int rst_at);
    q_t seq;
    seq = seq_of(op);
    opcode = op;
    for (int k = 0; k < seq.size(); k++) begin
      if (k == rst_at) begin
        do_reset(seq[k]);
        return;
      end
      check_cycle(seq[k], 1'b0);
      @(posedge clk);
      #1;
      if (k == 1 && !is_legal(op)) illegal_m = 1'b1;
      if (k == seq.size() - 1 && is_legal(op)) retired_m = (retired_m + 1) % (1 << CNT_W);
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int len;
    ops = '{LW, SW, RT, BEQ, JMP, ADDI};
    @(posedge clk);
    #1;
    retired_m = 0;
    illegal_m = 1'b0;
    check_cycle(0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(LW, -1);
    run_instr(SW, -1);
    run_instr(RT, -1);
    run_instr(BEQ, -1);
    run_instr(JMP, -1);
    run_instr(6'b111111, -1);
    run_instr(ADDI, -1);
    run_instr(RT, 3);
    for (int i = 0; i < 16; i++) run_instr(JMP, -1);
    check("wrap", {28'b0, retired}, 0);
    run_instr(ADDI, -1);
    for (int i = 0; i < 80; i++) begin
      op = ($urandom % 5 == 0) ? 6'($urandom) : ops[$urandom % 6];
      len = seq_of(op).size();
      run_instr(op, ($urandom % 8 == 0) ? int'($urandom_range(0, len - 1)) : -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle control unit for the BEQ-capable MIPS-subset datapath.
- Sequences instruction fetch, register-file read, ALU, memory and register-file write-back, one instruction at a time.
- Drives every datapath enable and mux select, including the register-file write enable, so register writes happen on exactly one clock edge per instruction.
- Also keeps an instruction-retired counter and a sticky illegal-opcode flag for bench checking.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; valid in DECODE.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (BEQ).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write-data select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  write register select: 0=rt, 1=rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A reg.
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- alu_op  out  2  to ALU control: 00=add, 01=sub, 10=funct field.
- pc_source  out  2  PC select: 00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.
- illegal  out  1  sticky; set on an undefined opcode.

Behaviour:
- Moore FSM with a 4-bit state register. All control outputs decode combinationally from the state only; opcode affects next state only.
- Encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR.
  - 6 EXEC, 7 ALUWB, 8 BRANCH, 9 JUMP, 10 ADDIEX, 11 ADDIWB.
  - 12-15 are unused and go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state is 0 in that state.
- FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00. Next: DECODE.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Next by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) -> ADDIEX.
  - any other opcode -> FETCH, and set illegal.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD for lw, MEMWR for sw (opcode is held stable by the IR).
- MEMRD: mem_read=1, i_or_d=1. Next: MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Next: FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. An illegal opcode costs 2 cycles.
- reg_write is high for exactly one cycle per lw, R-type or addi, and never for sw, beq, j or an illegal opcode.
- retired increments by 1 on the rising edge that leaves MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB. It wraps from all-ones to 0. An illegal opcode does not increment it.
- illegal: set on the edge leaving DECODE with an undefined opcode; cleared only by reset.
- Reset, synchronous active-high:
  - On the next edge: state=FETCH, retired=0, illegal=0.
  - While reset is high, pc_write, pc_write_cond, ir_write, mem_write and reg_write are forced to 0, whatever the state. Other outputs follow the state decode.
  - Reset asserted mid-instruction (e.g. in MEMWR or ALUWB) must suppress that cycle's write strobe in the same cycle.
  - The first cycle after reset deasserts is a normal FETCH with pc_write=1.

Test Plan:
- Reset held 2 cycles from an arbitrary state, then released -> state=0, retired=0, illegal=0, all write strobes 0 during reset; first post-reset cycle has mem_read=1, ir_write=1, pc_write=1.
- opcode=100011 (lw) -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired 0->1.
- opcode=101011 (sw), then 000000 (R-type) -> sw: 0,1,2,5 with mem_write=1 only in state 5. R-type: 0,1,6,7 with alu_op=10 in state 6 and reg_write=1, reg_dst=1 in state 7. retired ends at 2.
- opcode=000100 (beq), then 000010 (j) -> beq: 0,1,8 with pc_write_cond=1, alu_op=01. j: 0,1,9 with pc_write=1, pc_source=10. Neither asserts reg_write; retired ends at 2.
- opcode=111111 in DECODE -> next state=0, illegal=1 and stays 1 through a following addi (0,1,10,11); retired counts only the addi.
- reset asserted during ALUWB -> reg_write=0 in that cycle, state=0 next edge; retired not incremented. Separately, preload retired to all-ones via 2^CNT_W-1 instructions (or CNT_W=4 and 15 instructions), complete one more -> retired wraps to 0.
